// File: rtl/cordic_pkg.sv
// Shared constants, the arctangent table and the FSM state type for the iterative CORDIC rotator.
// Optional build macro used by this slice: CORDIC_SHIFT_RND_EN (round-to-nearest shifted terms).
package cordic_pkg;

  localparam int ANG_W_DEF = 16;
  localparam int OUT_W_DEF = ANG_W_DEF + 1;
  localparam int MAX_ITERS = 16;
  localparam int X_INIT    = 16384;   // 1.0 in Q3.14
  localparam int HALF_PI   = 25736;   // pi/2 in Q2.14

  // atan(2^-i) in Q2.14
  localparam logic [15:0] ATAN_TAB [MAX_ITERS] = '{
    16'd12868, 16'd7596, 16'd4014, 16'd2037, 16'd1023, 16'd512, 16'd256, 16'd128,
    16'd64,    16'd32,   16'd16,   16'd8,    16'd4,    16'd2,   16'd1,   16'd1
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/cordic_rot_iter_if.sv
// Angle-in / cos-sin-out handshake bundle of the CORDIC rotator.
interface cordic_rot_iter_if #(
  parameter int ANG_W = 16,
  parameter int OUT_W = 17
) ();

  logic                    in_valid;
  logic                    in_ready;
  logic signed [ANG_W-1:0] in_theta;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_x;
  logic signed [OUT_W-1:0] out_y;
  logic                    out_clamped;

  modport master (
    output in_valid, in_theta, out_ready,
    input  in_ready, out_valid, out_x, out_y, out_clamped
  );

  modport slave (
    input  in_valid, in_theta, out_ready,
    output in_ready, out_valid, out_x, out_y, out_clamped
  );

endinterface

// File: rtl/cordic_atan_rom.sv
// Combinational iteration-index to atan(2^-i) lookup; swap this module for a deeper table.
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int ANG_W = ANG_W_DEF
) (
  input  logic [3:0]       idx,
  output logic [ANG_W-1:0] atan
);

  assign atan = ANG_W'(ATAN_TAB[idx]);

endmodule

// File: rtl/cordic_rot_iter.sv
// Iterative CORDIC rotation engine: one micro-rotation per clock, unscaled (gain K) cos/sin out.
// Build macro CORDIC_SHIFT_RND_EN selects round-to-nearest shifted terms instead of floor.
module cordic_rot_iter
  import cordic_pkg::*;
#(
  parameter int ITERS = 16,
  parameter int ANG_W = ANG_W_DEF,
  parameter int OUT_W = ANG_W + 1
) (
  input logic             ap_clk,
  input logic             ap_rst_n,
  cordic_rot_iter_if.slave io
);

  localparam logic signed [ANG_W:0]   Z_MAX  = (ANG_W+1)'(HALF_PI);
  localparam logic signed [ANG_W:0]   Z_MIN  = -Z_MAX;
  localparam logic signed [OUT_W-1:0] X_ONE  = OUT_W'(X_INIT);
  localparam logic [3:0]              I_LAST = 4'(ITERS - 1);

  state_t                  state_q, state_d;
  logic signed [OUT_W-1:0] x_q, y_q, out_x_q, out_y_q;
  logic signed [ANG_W:0]   z_q;
  logic [3:0]              i_q;
  logic                    clamp_q, out_clamped_q;

  logic                    in_ready, accept, last;
  logic signed [ANG_W:0]   theta_ext, theta_sat;
  logic                    theta_hit;
  logic [ANG_W-1:0]        atan;
  logic signed [ANG_W:0]   atan_ext;
  logic signed [OUT_W-1:0] xs, ys, x_rot, y_rot;
  logic signed [ANG_W:0]   z_rot;

  function automatic logic signed [OUT_W-1:0] shift_term(
    input logic signed [OUT_W-1:0] v,
    input logic [3:0]              sh
  );
`ifdef CORDIC_SHIFT_RND_EN
    // Extra bit keeps the rounding bias from overflowing before the shift.
    logic signed [OUT_W:0] bias;
    logic signed [OUT_W:0] sum;
    bias = '0;
    if (sh != 4'd0) bias[sh - 4'd1] = 1'b1;
    sum = {v[OUT_W-1], v} + bias;
    sum = sum >>> sh;
    return sum[OUT_W-1:0];
`else
    return v >>> sh;
`endif
  endfunction

  cordic_atan_rom #(.ANG_W(ANG_W)) u_atan_rom (
    .idx  (i_q),
    .atan (atan)
  );

  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && io.out_ready);
  assign accept   = io.in_valid && in_ready;
  assign last     = (i_q == I_LAST);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    theta_ext = {io.in_theta[ANG_W-1], io.in_theta};
    theta_sat = theta_ext;
    theta_hit = 1'b0;
    if (theta_ext > Z_MAX) begin
      theta_sat = Z_MAX;
      theta_hit = 1'b1;
    end else if (theta_ext < Z_MIN) begin
      theta_sat = Z_MIN;
      theta_hit = 1'b1;
    end
  end

  always_comb begin
    atan_ext = {1'b0, atan};
    xs       = shift_term(x_q, i_q);
    ys       = shift_term(y_q, i_q);
    x_rot    = x_q;
    y_rot    = y_q;
    z_rot    = z_q;
    if (!z_q[ANG_W]) begin
      x_rot = x_q - ys;
      y_rot = y_q + xs;
      z_rot = z_q - atan_ext;
    end else begin
      x_rot = x_q + ys;
      y_rot = y_q - xs;
      z_rot = z_q + atan_ext;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (io.in_valid) state_d = ROTATE;
      ROTATE:  if (last) state_d = DONE;
      DONE:    if (io.out_ready) state_d = io.in_valid ? ROTATE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: the reset clears the whole datapath, so an aborted rotation leaves nothing behind.
    if (!ap_rst_n) begin
      state_q       <= IDLE;
      x_q           <= '0;
      y_q           <= '0;
      z_q           <= '0;
      i_q           <= '0;
      clamp_q       <= 1'b0;
      out_x_q       <= '0;
      out_y_q       <= '0;
      out_clamped_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        x_q     <= X_ONE;
        y_q     <= '0;
        z_q     <= theta_sat;
        i_q     <= '0;
        clamp_q <= theta_hit;
      end else if (state_q == ROTATE) begin
        x_q <= x_rot;
        y_q <= y_rot;
        z_q <= z_rot;
        i_q <= i_q + 4'd1;
        // Results are captured only on the final iteration, so outputs never show partial work.
        if (last) begin
          out_x_q       <= x_rot;
          out_y_q       <= y_rot;
          out_clamped_q <= clamp_q;
        end
      end
    end
  end

  assign io.in_ready    = in_ready;
  assign io.out_valid   = (state_q == DONE);
  assign io.out_x       = out_x_q;
  assign io.out_y       = out_y_q;
  assign io.out_clamped = out_clamped_q;

endmodule

// File: doc/cordic_rot_iter.md
Name: cordic_rot_iter

Overview:
Iterative, single-datapath CORDIC rotation engine that sits directly upstream of the signed 17x16 gain-compensation multiplier.
- Accepts one signed angle; runs ITERS shift-add micro-rotations, one per clock.
- Emits unscaled cos/sin (gain K≈1.64676 still applied) as 17-bit signed words; the downstream multiplier multiplies these by the 16-bit 1/K constant.

Parameters:
- ITERS, 16: number of micro-rotations; legal range 1..16.
- ANG_W, 16: angle width, signed Q2.14 (radians).
- OUT_W, 17: x/y datapath and output width, signed Q3.14; fixed at ANG_W+1.

Ports:
- ap_clk  in  1  clock; all state updates on the rising edge.
- ap_rst_n  in  1  synchronous reset, active-low.
- in_valid  in  1  in_theta is valid.
- in_ready  out  1  block can accept an angle this cycle.
- in_theta  in  ANG_W  signed angle, Q2.14.
- out_valid  out  1  out_x, out_y and out_clamped are valid.
- out_ready  in  1  consumer accepts the result.
- out_x  out  OUT_W  K·cos(theta), Q3.14.
- out_y  out  OUT_W  K·sin(theta), Q3.14.
- out_clamped  out  1  input was saturated to ±pi/2.

Behaviour:
- Reset (ap_rst_n=0 at a clock edge):
  - state=IDLE; x, y, z, iteration counter and all outputs = 0.
  - Reset abandons any rotation in progress; no partial result is ever presented.
- States:
  - IDLE: in_ready=1. On in_valid, go to ROTATE.
  - ROTATE: in_ready=0. Count i from 0 to ITERS-1. After iteration ITERS-1, go to DONE.
  - DONE: out_valid=1.
    - out_ready=1 and in_valid=1: accept the new angle in the same cycle and go to ROTATE.
    - out_ready=1 and in_valid=0: go to IDLE.
    - out_ready=0: hold.
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
- Accept (in_valid && in_ready):
  - x ← 16384 (1.0).
  - y ← 0.
  - z ← clamp(in_theta, -25736, +25736).
  - clamp flag ← 1 if clamping occurred.
  - i ← 0.
- Iteration i, with d = +1 if z ≥ 0, else -1:
  - x ← x − d·(y>>>i).
  - y ← y + d·(x>>>i), using the pre-update x.
  - z ← z − d·ATAN[i].
  - Arithmetic shifts on signed OUT_W values. No saturation in x/y: Q3.14 headroom covers |x|,|y| ≤ 1.65.
  - z is ANG_W+1 bits internally; wrap cannot occur for clamped inputs.
- ATAN table, Q2.14, i = 0..15: 12868, 7596, 4014, 2037, 1023, 512, 256, 128, 64, 32, 16, 8, 4, 2, 1, 1.
- Latency and throughput:
  - out_valid rises exactly ITERS clock edges after the accepting edge.
  - Throughput is one result per ITERS+1 cycles when back-to-back (DONE→ROTATE direct).
- Output hold: out_x, out_y and out_clamped are registered and stable for the whole time out_valid=1. They keep their last values after the handshake until the next DONE.
- Boundary inputs:
  - in_theta = ±25736 is not flagged.
  - in_theta = -32768 clamps to -25736, flag=1.

Optional Feature:
CORDIC_SHIFT_RND_EN.
- Defined: for i ≥ 1, each shifted term is rounded to nearest, computed as (v + (1<<(i-1)))>>>i. This reduces accumulated bias.
- Undefined: plain arithmetic-shift truncation (floor).
- Latency, handshake and ATAN table are identical in both builds.

Decomposition:
- cordic_pkg holds:
  - ANG_W/OUT_W defaults.
  - Constants X_INIT=16384 and HALF_PI=25736.
  - The ATAN table as a constant array.
  - A state enum {IDLE, ROTATE, DONE}.
- One natural sub-module: cordic_atan_rom, a combinational index→ATAN lookup, so a deeper table can replace it later.

Test Plan:
- Zero angle: in_theta=0 → out_x=26981±16, out_y=0±16, out_clamped=0; out_valid exactly 16 cycles after accept.
- Quarter angles: in_theta=12868 (pi/4) → out_x≈out_y≈19078±16. in_theta=-12868 → out_x≈19078, out_y≈-19078±16.
- Edge and clamp: in_theta=25736 → out_x≈0±16, out_y≈26981±16, out_clamped=0. in_theta=30000 and in_theta=-32768 → results equal those for ±25736, out_clamped=1.
- Backpressure and back-to-back: hold out_ready=0 for 5 cycles in DONE → outputs stable, in_ready=0. Then out_ready=1 with in_valid=1 → new angle accepted the same cycle, next out_valid 16 cycles later.
- Reset mid-rotation: assert ap_rst_n=0 at i=7 for one cycle → next cycle state=IDLE, out_valid=0, outputs 0, in_ready=1. A fresh angle then completes correctly.
- Bit-exact check: 1000 random angles compared against a C model, run in both CORDIC_SHIFT_RND_EN builds.
